// File: rtl/tube_pkg.sv
// Shared types and constants for the Tube host-bus master: FSM states,
// Tube host register map and counter widths.
package tube_pkg;

    localparam int PHASE_W = 4;
    localparam int RST_W   = 8;

    typedef enum logic [2:0] {
        ST_RSTW   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_HOLD   = 3'd4
    } state_e;

    // Host-side Tube registers: status/data pairs for FIFOs R1..R4
    localparam logic [2:0] REG_R1_STATUS = 3'd0;
    localparam logic [2:0] REG_R1_DATA   = 3'd1;
    localparam logic [2:0] REG_R2_STATUS = 3'd2;
    localparam logic [2:0] REG_R2_DATA   = 3'd3;
    localparam logic [2:0] REG_R3_STATUS = 3'd4;
    localparam logic [2:0] REG_R3_DATA   = 3'd5;
    localparam logic [2:0] REG_R4_STATUS = 3'd6;
    localparam logic [2:0] REG_R4_DATA   = 3'd7;

endpackage

// File: rtl/tube_bus_master_if.sv
// Request/response handshake plus Tube host-bus pins for tube_bus_master.
// The master modport is the bus master itself; slave is its environment.
interface tube_bus_master_if;

    logic       req_valid;
    logic       req_ready;
    logic       req_rnw;
    logic [2:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       T_HCS_B;
    logic       T_RNW;
    logic       T_PHI2;
    logic       T_HRST_B;
    logic [2:0] T_HA;
    logic [7:0] T_HD_out;
    logic       T_HD_oe;
    logic [7:0] T_HD_in;
    logic       T_HIRQ_B;
    logic       irq;

    modport master (
        input  req_valid, req_rnw, req_addr, req_wdata, T_HD_in, T_HIRQ_B,
        output req_ready, rsp_valid, rsp_rdata,
        output T_HCS_B, T_RNW, T_PHI2, T_HRST_B, T_HA, T_HD_out, T_HD_oe, irq
    );

    modport slave (
        output req_valid, req_rnw, req_addr, req_wdata, T_HD_in, T_HIRQ_B,
        input  req_ready, rsp_valid, rsp_rdata,
        input  T_HCS_B, T_RNW, T_PHI2, T_HRST_B, T_HA, T_HD_out, T_HD_oe, irq
    );

endinterface

// File: rtl/tube_irq_sync.sv
// Two-flop synchroniser for the active-low host interrupt; idles at 1
// (interrupt deasserted) out of reset.
module tube_irq_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    // Synchroniser chain
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/tube_bus_master.sv
// Tube host-bus master: turns single req/rsp accesses into timed
// HCS/PHI2 bus cycles. Define TUBE_IRQ_SYNC_EN to synchronise T_HIRQ_B.
module tube_bus_master
    import tube_pkg::*;
#(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 1,
    parameter int RST_CYC    = 8
) (
    input logic              CLK,
    input logic              RESET,
    tube_bus_master_if.master bus
);

    localparam logic [PHASE_W-1:0] SETUP_LAST  = PHASE_W'(SETUP_CYC - 1);
    localparam logic [PHASE_W-1:0] STROBE_LAST = PHASE_W'(STROBE_CYC - 1);
    localparam logic [PHASE_W-1:0] HOLD_LAST   = PHASE_W'(HOLD_CYC - 1);
    localparam logic [RST_W-1:0]   RST_LAST    = RST_W'(RST_CYC - 1);

    state_e             state_q, state_d;
    logic [PHASE_W-1:0] pcnt_q, pcnt_d;
    logic [RST_W-1:0]   rcnt_q, rcnt_d;
    logic               rnw_q, rnw_d;
    logic [2:0]         addr_q, addr_d;
    logic [7:0]         wdata_q, wdata_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               ready_q, ready_d;
    logic               hcs_q, hcs_d;
    logic               trnw_q, trnw_d;
    logic               phi2_q, phi2_d;
    logic               oe_q, oe_d;
    logic               hrst_q, hrst_d;
    logic [2:0]         ha_q, ha_d;
    logic [7:0]         hdo_q, hdo_d;

    // Next-state, phase counting, request latching and read capture
    always_comb begin
        state_d     = state_q;
        pcnt_d      = pcnt_q;
        rcnt_d      = rcnt_q;
        rnw_d       = rnw_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;
        case (state_q)
            ST_RSTW: begin
                if (rcnt_q == RST_LAST) begin
                    state_d = ST_IDLE;
                    rcnt_d  = {RST_W{1'b0}};
                end else begin
                    rcnt_d  = rcnt_q + 8'd1;
                end
            end
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_d = ST_SETUP;
                    pcnt_d  = {PHASE_W{1'b0}};
                    rnw_d   = bus.req_rnw;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (pcnt_q == SETUP_LAST) begin
                    state_d = ST_STROBE;
                    pcnt_d  = {PHASE_W{1'b0}};
                end else begin
                    pcnt_d  = pcnt_q + 4'd1;
                end
            end
            ST_STROBE: begin
                if (pcnt_q == STROBE_LAST) begin
                    state_d     = ST_HOLD;
                    pcnt_d      = {PHASE_W{1'b0}};
                    rsp_valid_d = 1'b1;
                    if (rnw_q) begin
                        rdata_d = bus.T_HD_in;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    pcnt_d = pcnt_q + 4'd1;
                end
            end
            ST_HOLD: begin
                if (pcnt_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                    pcnt_d  = {PHASE_W{1'b0}};
                end else begin
                    pcnt_d  = pcnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_RSTW;
                rcnt_d  = {RST_W{1'b0}};
            end
        endcase
    end

    // Bus pin values for the upcoming state, so every pin leaves a flop
    always_comb begin
        hcs_d   = 1'b1;
        trnw_d  = 1'b1;
        phi2_d  = 1'b0;
        oe_d    = 1'b0;
        hrst_d  = 1'b1;
        ha_d    = ha_q;
        hdo_d   = hdo_q;
        ready_d = 1'b0;
        case (state_d)
            ST_RSTW: begin
                hrst_d = 1'b0;
                ha_d   = 3'd0;
                hdo_d  = 8'd0;
            end
            ST_IDLE: begin
                ready_d = 1'b1;
            end
            ST_SETUP, ST_STROBE, ST_HOLD: begin
                hcs_d  = 1'b0;
                ha_d   = addr_d;
                trnw_d = rnw_d;
                oe_d   = ~rnw_d;
                hdo_d  = wdata_d;
                phi2_d = (state_d == ST_STROBE);
            end
            default: begin
                hrst_d = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_RSTW;
            pcnt_q      <= {PHASE_W{1'b0}};
            rcnt_q      <= {RST_W{1'b0}};
            rnw_q       <= 1'b1;
            addr_q      <= 3'd0;
            wdata_q     <= 8'd0;
            rdata_q     <= 8'd0;
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b0;
            hcs_q       <= 1'b1;
            trnw_q      <= 1'b1;
            phi2_q      <= 1'b0;
            oe_q        <= 1'b0;
            hrst_q      <= 1'b0;
            ha_q        <= 3'd0;
            hdo_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            pcnt_q      <= pcnt_d;
            rcnt_q      <= rcnt_d;
            rnw_q       <= rnw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            ready_q     <= ready_d;
            hcs_q       <= hcs_d;
            trnw_q      <= trnw_d;
            phi2_q      <= phi2_d;
            oe_q        <= oe_d;
            hrst_q      <= hrst_d;
            ha_q        <= ha_d;
            hdo_q       <= hdo_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.T_HCS_B   = hcs_q;
    assign bus.T_RNW     = trnw_q;
    assign bus.T_PHI2    = phi2_q;
    assign bus.T_HRST_B  = hrst_q;
    assign bus.T_HA      = ha_q;
    assign bus.T_HD_out  = hdo_q;
    assign bus.T_HD_oe   = oe_q;

`ifdef TUBE_IRQ_SYNC_EN
    logic hirq_b_sync;

    tube_irq_sync u_irq_sync (
        .clk_i (CLK),
        .rst_i (RESET),
        .d_i   (bus.T_HIRQ_B),
        .q_o   (hirq_b_sync)
    );

    assign bus.irq = ~hirq_b_sync;
`else
    assign bus.irq = ~bus.T_HIRQ_B;
`endif

endmodule

// File: tb/tb_tube_bus_master.sv
// Scoreboard bench for tube_bus_master with default timing parameters
// (setup 2, strobe 4, hold 1, reset wait 8).
module tb_tube_bus_master;
    import tube_pkg::*;

`ifdef TUBE_IRQ_SYNC_EN
    localparam int IRQ_LAT = 2;
`else
    localparam int IRQ_LAT = 0;
`endif

    logic CLK = 1'b0;
    logic RESET;

    tube_bus_master_if bus ();

    tube_bus_master dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] rdata;
        int         at;
    } rsp_t;

    typedef struct {
        logic       rnw;
        logic [2:0] addr;
        logic [7:0] wdata;
        int         low;
        int         phi;
    } acc_t;

    rsp_t rsp_q[$];
    acc_t acc_q[$];

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         hd_cyc = -1;
    logic [7:0] hd_val = 8'h00;

    rsp_t mon_e;
    acc_t cur;
    bit   in_acc = 1'b0;
    bit   fld_ok;
    int   low_cnt, phi_cnt, setup_cnt;
    int   gap_cnt = 0;
    int   last_gap = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycle counter; host data bus shows hd_val only during the chosen cycle
    always @(posedge CLK) begin
        cyc = cyc + 1;
        #1;
        bus.T_HD_in = (cyc == hd_cyc) ? hd_val : 8'hFF;
    end

    // Response monitor: pop expected data and completion cycle
    always @(negedge CLK) begin
        if (bus.rsp_valid === 1'b1) begin
            if (rsp_q.size() == 0) begin
                check("unexpected rsp_valid", 32'd1, 32'd0);
            end else begin
                mon_e = rsp_q.pop_front();
                check("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
                check("rsp latency cycle", cyc, mon_e.at);
            end
        end
    end

    // Bus monitor: phase lengths, field stability and idle gaps
    always @(negedge CLK) begin
        if (bus.T_HCS_B === 1'b0) begin
            if (!in_acc) begin
                in_acc    = 1'b1;
                last_gap  = gap_cnt;
                low_cnt   = 0;
                phi_cnt   = 0;
                setup_cnt = 0;
                fld_ok    = 1'b1;
                if (acc_q.size() == 0) begin
                    check("unexpected bus access", 32'd1, 32'd0);
                    cur.rnw = 1'b1; cur.addr = 3'd0; cur.wdata = 8'd0;
                    cur.low = -1;   cur.phi = -1;
                end else begin
                    cur = acc_q.pop_front();
                end
            end
            low_cnt++;
            if (bus.T_PHI2 === 1'b1) phi_cnt++;
            else if (phi_cnt == 0) setup_cnt++;
            if (bus.T_HA !== cur.addr || bus.T_RNW !== cur.rnw || bus.T_HD_oe !== ~cur.rnw ||
                (!cur.rnw && bus.T_HD_out !== cur.wdata))
                fld_ok = 1'b0;
        end else begin
            if (in_acc) begin
                in_acc = 1'b0;
                check("HCS_B low cycles", low_cnt, cur.low);
                check("PHI2 high cycles", phi_cnt, cur.phi);
                check("setup cycles", setup_cnt, 32'd2);
                check("bus fields stable", {31'd0, fld_ok}, 32'd1);
                gap_cnt = 0;
            end
            gap_cnt++;
        end
    end

    // Issue one access (called just after a rising edge); returns at accept+1
    task automatic do_access(input logic rnw, input logic [2:0] addr, input logic [7:0] wdata,
                             input logic [7:0] exp_rd, input bit keep, input bit abort,
                             output int acc_cyc);
        int   n;
        acc_t a;
        rsp_t r;
        bus.req_rnw   = rnw;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_valid = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (bus.req_ready !== 1'b1 && n < 50);
        check("req_ready within budget", {31'd0, bus.req_ready}, 32'd1);
        acc_cyc = cyc;
        a.rnw = rnw; a.addr = addr; a.wdata = wdata;
        a.low = abort ? 4 : 7;
        a.phi = abort ? 2 : 4;
        acc_q.push_back(a);
        if (!abort) begin
            r.rdata = exp_rd;
            r.at    = cyc + 7;
            rsp_q.push_back(r);
        end
        if (rnw) hd_cyc = cyc + 6;
        @(posedge CLK);
        #1;
        bus.req_rnw   = ~rnw;
        bus.req_addr  = ~addr;
        bus.req_wdata = ~wdata;
        bus.req_valid = keep;
    endtask

    // RSTW window: 8 cycles of host reset, then ready on the 9th
    task automatic check_rst_release();
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            check("HRST_B low in RSTW", {31'd0, bus.T_HRST_B}, 32'd0);
            check("req_ready low in RSTW", {31'd0, bus.req_ready}, 32'd0);
            check("HCS_B high in RSTW", {31'd0, bus.T_HCS_B}, 32'd1);
        end
        @(negedge CLK);
        check("HRST_B after RSTW", {31'd0, bus.T_HRST_B}, 32'd1);
        check("req_ready on 9th cycle", {31'd0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        int n1, n2, n3, k;
        RESET         = 1'b1;
        bus.T_HIRQ_B  = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_rnw   = 1'b0;
        bus.req_addr  = 3'd0;
        bus.req_wdata = 8'd0;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset HRST_B", {31'd0, bus.T_HRST_B}, 32'd0);
        check("reset HCS_B", {31'd0, bus.T_HCS_B}, 32'd1);
        check("reset RNW", {31'd0, bus.T_RNW}, 32'd1);
        check("reset PHI2", {31'd0, bus.T_PHI2}, 32'd0);
        check("reset HD_oe", {31'd0, bus.T_HD_oe}, 32'd0);
        check("reset HA", {29'd0, bus.T_HA}, 32'd0);
        check("reset HD_out", {24'd0, bus.T_HD_out}, 32'd0);
        check("reset rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("reset rsp_rdata", {24'd0, bus.rsp_rdata}, 32'd0);
        check("reset req_ready", {31'd0, bus.req_ready}, 32'd0);
        check("reset irq", {31'd0, bus.irq}, 32'd0);

        @(posedge CLK); #1;
        RESET = 1'b0;
        check_rst_release();

        // Single write, then single read
        @(posedge CLK); #1;
        do_access(1'b0, REG_R2_DATA, 8'hA5, 8'h00, 1'b0, 1'b0, n1);
        hd_val = 8'h3C;
        do_access(1'b1, REG_R1_DATA, 8'h00, 8'h3C, 1'b0, 1'b0, n1);

        // Back-to-back with req_valid held; second request scrambled after accept
        do_access(1'b0, REG_R2_STATUS, 8'h5A, 8'h3C, 1'b1, 1'b0, n1);
        hd_val = 8'hC3;
        do_access(1'b1, REG_R3_DATA, 8'h00, 8'hC3, 1'b0, 1'b0, n2);
        check("back-to-back accept spacing", n2 - n1, 32'd8);
        repeat (10) @(negedge CLK);
        check("idle gap between accesses", last_gap, 32'd1);

        // Interrupt path
        check("irq idle", {31'd0, bus.irq}, 32'd0);
        @(posedge CLK); #1;
        bus.T_HIRQ_B = 1'b0;
        for (k = 0; k < 3; k++) begin
            @(negedge CLK);
            check("irq latency", {31'd0, bus.irq}, (k >= IRQ_LAT) ? 32'd1 : 32'd0);
        end
        @(posedge CLK); #1;
        bus.T_HIRQ_B = 1'b1;
        repeat (3) @(negedge CLK);
        check("irq released", {31'd0, bus.irq}, 32'd0);

        // Reset during the second strobe cycle abandons the read
        @(posedge CLK); #1;
        hd_val = 8'h77;
        do_access(1'b1, REG_R4_DATA, 8'h00, 8'h00, 1'b0, 1'b1, n3);
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET  = 1'b0;
        hd_cyc = -1;
        check_rst_release();
        check("rsp_rdata cleared by reset", {24'd0, bus.rsp_rdata}, 32'd0);

        // Traffic after the abort; writes leave read data untouched
        @(posedge CLK); #1;
        do_access(1'b0, REG_R1_STATUS, 8'h11, 8'h00, 1'b0, 1'b0, n1);
        hd_val = 8'h96;
        do_access(1'b1, REG_R4_STATUS, 8'h00, 8'h96, 1'b0, 1'b0, n1);
        do_access(1'b0, REG_R3_STATUS, 8'hC0, 8'h96, 1'b0, 1'b0, n1);

        k = 0;
        while ((rsp_q.size() != 0 || acc_q.size() != 0 || in_acc) && k < 40) begin
            @(negedge CLK);
            k++;
        end
        @(negedge CLK);
        check("responses drained", rsp_q.size(), 32'd0);
        check("bus accesses drained", acc_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
